inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), one clock, synchronous active-low reset:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_fmt  in  2  0=R, 1=I (load), 2=S, 3=SB
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  64  signed immediate, two's complement
- base_load  in  1  load address counter
- base_addr  in  64  new address
- out_valid  out  1  FIFO head valid
- out_ready  in  1  head consumed when out_valid&&out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  64  byte address of out_instr
- out_err  out  1  immediate-range error for out_instr
- err_count  out  8  saturating count of accepted erroneous requests

Function
REQ-002 SHALL encode opcodes: R=0110011, I=0000011, S=0100011, SB=1100011.
REQ-003 R SHALL be funct7|rs2|rs1|funct3|rd|op; in_imm ignored, never an error.
REQ-004 I SHALL be imm[11:0]|rs1|funct3|rd|op; error if in_imm outside [-2048, 2047].
REQ-005 S SHALL be imm[11:5]|rs2|rs1|funct3|imm[4:0]|op; error if in_imm outside [-2048, 2047].
REQ-006 SB SHALL be imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op; error if in_imm outside [-4096, 4094] or in_imm[0]=1.
REQ-007 Erroneous requests SHALL still be accepted and emitted, with the immediate truncated to the format's bits and out_err=1.
REQ-008 Encoded result, address and error flag SHALL be written into a 2-entry FIFO on acceptance; latency from acceptance to out_valid SHALL be exactly 1 cycle when FIFO was empty.
REQ-009 in_ready SHALL be 1 iff FIFO occupancy < 2, a function of registered occupancy only (no combinational path from out_ready).
REQ-010 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1, with the new entry behind the popped one.
REQ-011 Outputs out_instr/out_addr/out_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-012 Address counter pc SHALL give each accepted request address pc, then pc <= pc + 4 (64-bit wrap-around, FFFF_FFFF_FFFF_FFFC -> 0).
REQ-013 base_load=1 without acceptance SHALL set pc <= {base_addr[63:2], 2'b00}.
REQ-014 base_load=1 coincident with acceptance SHALL give the request address {base_addr[63:2],2'b00} and set pc to that +4.
REQ-015 err_count SHALL increment by 1 per accepted erroneous request and saturate at 255.
REQ-016 in_valid=0 SHALL never alter FIFO, pc or err_count (base_load excepted).

Reset
REQ-017 rst_n=0 at a rising edge SHALL set FIFO empty, out_valid=0, in_ready=1 in the following cycle, pc=0, err_count=0, out_instr=0, out_addr=0, out_err=0.
REQ-018 Reset mid-operation SHALL discard all buffered entries; requests presented during reset SHALL NOT be accepted.

Verification
REQ-019 R: rd=3, rs1=1, rs2=2, f3=0, f7=0 after reset -> next cycle out_instr=0x002081B3, out_addr=0, out_err=0.
REQ-020 I: rd=5, rs1=2, f3=3, imm=-8 -> 0xFF813283, err=0; imm=2048 -> err=1, err_count=1.
REQ-021 S: rs1=4, rs2=3, f3=3, imm=16 -> 0x00323823; SB: rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463; SB imm=7 -> err=1.
REQ-022 Backpressure: out_ready=0, three back-to-back requests -> third stalls with in_ready=0 after two; release -> order preserved, addresses 0, 4, 8.
REQ-023 base_load with base_addr=0x1003 coincident with acceptance -> out_addr=0x1000; next request gets 0x1004; reset with 2 entries buffered -> out_valid=0, err_count=0.

Source files
------------

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32 R/I/S/SB instruction encoder with address counter and 2-entry output FIFO
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  input  logic        base_load,
  input  logic [63:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [1:0] FMT_R  = 2'd0;
  localparam logic [1:0] FMT_I  = 2'd1;
  localparam logic [1:0] FMT_S  = 2'd2;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_SB = 7'b1100011;

  // FIFO storage: two slots addressed by 1-bit read/write pointers
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [63:0] addr_q  [2];
  logic [63:0] addr_d  [2];
  logic [1:0]  errf_q;
  logic [1:0]  errf_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [63:0] pc_q, pc_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits_12;
  logic        fits_13;
  logic [63:0] base_aligned;
  logic [63:0] req_addr;
  logic        push;
  logic        pop;

  // A value fits a signed N-bit field when every bit above N-1 matches the sign
  assign fits_12 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign fits_13 = (&in_imm[63:12]) | ~(|in_imm[63:12]);

  // Encode the presented request; out-of-range immediates are truncated and flagged
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (in_fmt)
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
        enc_err   = 1'b0;
      end
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
        enc_err   = ~fits_12;
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
        enc_err   = ~fits_12;
      end
      default: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_SB};
        enc_err   = ~fits_13 | in_imm[0];
      end
    endcase
  end

  // Handshakes depend on registered occupancy only, never on out_ready
  assign in_ready     = (count_q != 2'd2);
  assign out_valid    = (count_q != 2'd0);
  assign push         = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign base_aligned = {base_addr[63:2], 2'b00};
  assign req_addr     = base_load ? base_aligned : pc_q;

  // Next-state for FIFO, address counter and error counter
  always_comb begin
    instr_d   = instr_q;
    addr_d    = addr_q;
    errf_d    = errf_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pc_d      = pc_q;
    err_cnt_d = err_cnt_q;

    if (push) begin
      instr_d[wr_ptr_q] = enc_instr;
      addr_d[wr_ptr_q]  = req_addr;
      errf_d[wr_ptr_q]  = enc_err;
      wr_ptr_d          = ~wr_ptr_q;
      pc_d              = req_addr + 64'd4;
      if (enc_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (base_load) begin
      pc_d = base_aligned;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset clearing all storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
      errf_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      pc_q       <= '0;
      err_cnt_q  <= '0;
    end else begin
      instr_q[0] <= instr_d[0];
      instr_q[1] <= instr_d[1];
      addr_q[0]  <= addr_d[0];
      addr_q[1]  <= addr_d[1];
      errf_q     <= errf_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_instr = instr_q[rd_ptr_q];
  assign out_addr  = addr_q[rd_ptr_q];
  assign out_err   = errf_q[rd_ptr_q];
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed self-checking bench for inst_encoder
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [63:0] in_imm;
  logic        base_load;
  logic [63:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .base_load (base_load),
    .base_addr (base_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] fmt, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [63:0] imm);
    in_fmt    = fmt;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  // Present one request for a single cycle (FIFO assumed not full)
  task automatic send(input logic [1:0] fmt, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [63:0] imm);
    set_req(fmt, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Check the FIFO head against expectations, then consume it
  task automatic expect_head(input string tag, input logic [31:0] instr,
                             input logic [63:0] addr, input logic err);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".instr"}, 64'(out_instr), 64'(instr));
    chk({tag, ".addr"},  out_addr, addr);
    chk({tag, ".err"},   64'(out_err), 64'(err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    base_load = 1'b0;
    base_addr = '0;
    set_req(2'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_instr", 64'(out_instr), 64'd0);
    chk("rst.out_addr",  out_addr,       64'd0);
    chk("rst.out_err",   64'(out_err),   64'd0);
    chk("rst.err_count", 64'(err_count), 64'd0);

    // R-type, one-cycle latency from acceptance
    send(2'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    chk("r.in_ready", 64'(in_ready), 64'd1);
    expect_head("r", 32'h002081B3, 64'd0, 1'b0);
    chk("r.drained", 64'(out_valid), 64'd0);

    // I-type and its range boundaries
    send(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, -64'sd8);
    expect_head("i_m8", 32'hFF813283, 64'd4, 1'b0);
    send(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, 64'd2048);
    expect_head("i_2048", 32'h80013283, 64'd8, 1'b1);
    chk("i_2048.err_count", 64'(err_count), 64'd1);
    send(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, 64'd2047);
    expect_head("i_2047", 32'h7FF13283, 64'd12, 1'b0);
    send(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, -64'sd2048);
    expect_head("i_m2048", 32'h80013283, 64'd16, 1'b0);
    send(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, -64'sd2049);
    expect_head("i_m2049", 32'h7FF13283, 64'd20, 1'b1);

    // S-type and SB-type
    send(2'd2, 3'd3, 7'd0, 5'd0, 5'd4, 5'd3, 64'd16);
    expect_head("s_16", 32'h00323823, 64'd24, 1'b0);
    send(2'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8);
    expect_head("sb_8", 32'h00208463, 64'd28, 1'b0);
    send(2'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd7);
    expect_head("sb_7", 32'h00208363, 64'd32, 1'b1);
    send(2'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd4094);
    expect_head("sb_4094", 32'h7E208FE3, 64'd36, 1'b0);
    send(2'd3, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd4096);
    expect_head("sb_4096", 32'h80208063, 64'd40, 1'b1);
    send(2'd0, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 64'h8000_0000_0000_0000);
    expect_head("r_f7", 32'h402081B3, 64'd44, 1'b0);
    chk("err_count4", 64'(err_count), 64'd4);

    // base_load without acceptance, then backpressure with three requests
    base_load = 1'b1;
    base_addr = 64'd0;
    tick();
    base_load = 1'b0;
    send(2'd0, 3'd0, 7'd0, 5'd1, 5'd1, 5'd2, 64'd0);
    chk("bp.a.in_ready", 64'(in_ready), 64'd1);
    send(2'd0, 3'd0, 7'd0, 5'd2, 5'd1, 5'd2, 64'd0);
    chk("bp.b.in_ready", 64'(in_ready), 64'd0);
    set_req(2'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    in_valid = 1'b1;
    tick();
    chk("bp.c.in_ready", 64'(in_ready),  64'd0);
    chk("bp.hold.instr", 64'(out_instr), 64'h002080B3);
    chk("bp.hold.addr",  out_addr,       64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp.pop1.instr", 64'(out_instr), 64'h00208133);
    chk("bp.pop1.addr",  out_addr,       64'd4);
    chk("bp.pop1.in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.pushpop.valid", 64'(out_valid), 64'd1);
    chk("bp.pushpop.instr", 64'(out_instr), 64'h002081B3);
    chk("bp.pushpop.addr",  out_addr,       64'd8);
    chk("bp.pushpop.in_ready", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    chk("bp.empty", 64'(out_valid), 64'd0);

    // base_load coincident with acceptance
    base_load = 1'b1;
    base_addr = 64'h1003;
    send(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, -64'sd8);
    base_load = 1'b0;
    expect_head("bl", 32'hFF813283, 64'h1000, 1'b0);
    send(2'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    expect_head("bl_next", 32'h002081B3, 64'h1004, 1'b0);

    // 64-bit wrap of the address counter
    base_load = 1'b1;
    base_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    base_load = 1'b0;
    send(2'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    expect_head("wrap_hi", 32'h002081B3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(2'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    expect_head("wrap_0", 32'h002081B3, 64'd0, 1'b0);

    // err_count saturation: stream 260 erroneous requests through
    set_req(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, 64'd4096);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("sat.err_count", 64'(err_count), 64'd255);
    chk("sat.empty",     64'(out_valid), 64'd0);

    // Reset with two entries buffered, requests presented during reset
    send(2'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    send(2'd1, 3'd3, 7'd0, 5'd5, 5'd2, 5'd0, 64'd2048);
    chk("pre_rst.in_ready", 64'(in_ready), 64'd0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    tick();
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.err_count", 64'(err_count), 64'd0);
    chk("mid_rst.in_ready",  64'(in_ready),  64'd1);
    chk("mid_rst.out_instr", 64'(out_instr), 64'd0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_rst.out_valid", 64'(out_valid), 64'd0);
    send(2'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    expect_head("post_rst", 32'h002081B3, 64'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
